// File: rtl/ram8_scan_pkg.sv
// Shared definitions for the ram8_scan block:
// FSM encoding and dwell-counter sizing.
package ram8_scan_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_e;

   localparam int DWELL_MAX = 15;
   localparam int DWELL_W   = 4;

endpackage

// File: rtl/Mux8Way16.sv
// 8-way, 16-bit combinational selector used on the bank read path.
module Mux8Way16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [15:0] e,
   input  logic [15:0] f,
   input  logic [15:0] g,
   input  logic [15:0] h,
   input  logic [2:0]  sel,
   output logic [15:0] out
);

   always_comb begin
      out = a;
      case (sel)
         3'd0: out = a;
         3'd1: out = b;
         3'd2: out = c;
         3'd3: out = d;
         3'd4: out = e;
         3'd5: out = f;
         3'd6: out = g;
         3'd7: out = h;
         default: out = a;
      endcase
   end

endmodule

// File: rtl/ram8_bank.sv
// Eight 16-bit registers with a single write port.
// All entries flatten to eight outputs for the read mux.
module ram8_bank (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        load,
   input  logic [2:0]  waddr,
   input  logic [15:0] in,
   output logic [15:0] r0,
   output logic [15:0] r1,
   output logic [15:0] r2,
   output logic [15:0] r3,
   output logic [15:0] r4,
   output logic [15:0] r5,
   output logic [15:0] r6,
   output logic [15:0] r7
);

   logic [15:0] bank_q [8];
   logic [15:0] bank_d [8];

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         bank_d[i] = bank_q[i];
      end
      if (load) begin
         bank_d[waddr] = in;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) begin
            bank_q[i] <= 16'h0000;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            bank_q[i] <= bank_d[i];
         end
      end
   end

   assign r0 = bank_q[0];
   assign r1 = bank_q[1];
   assign r2 = bank_q[2];
   assign r3 = bank_q[3];
   assign r4 = bank_q[4];
   assign r5 = bank_q[5];
   assign r6 = bank_q[6];
   assign r7 = bank_q[7];

endmodule

// File: rtl/ram8_scan.sv
// Register bank with a scanning read pointer: in SCAN the pointer
// dwells DWELL cycles per entry and steps 0..7 cyclically.
module ram8_scan
   import ram8_scan_pkg::*;
#(
   parameter int DWELL = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        load,
   input  logic [2:0]  waddr,
   input  logic [15:0] in,
   input  logic        start,
   input  logic        stop,
   input  logic        ptr_load,
   input  logic [2:0]  ptr_in,
   output logic [2:0]  sel,
   output logic [15:0] out,
   output logic        valid,
   output logic        wrap
);

   // Out-of-range DWELL is clamped so the counter width always suffices.
   localparam int DWELL_C = (DWELL < 1) ? 1 : ((DWELL > DWELL_MAX) ? DWELL_MAX : DWELL);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_C - 1);

   logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

   scan_state_e        state_q, state_d;
   logic [2:0]         sel_q, sel_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               valid_q, valid_d;
   logic               wrap_q, wrap_d;
   logic               advance;

   ram8_bank u_bank (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (load),
      .waddr   (waddr),
      .in      (in),
      .r0      (r0),
      .r1      (r1),
      .r2      (r2),
      .r3      (r3),
      .r4      (r4),
      .r5      (r5),
      .r6      (r6),
      .r7      (r7)
   );

   Mux8Way16 u_mux (
      .a   (r0),
      .b   (r1),
      .c   (r2),
      .d   (r3),
      .e   (r4),
      .f   (r5),
      .g   (r6),
      .h   (r7),
      .sel (sel_q),
      .out (out)
   );

   // Advance is judged on the current state, so a stop arriving with a
   // pending advance still lets that final step happen.
   assign advance = (state_q == SCAN) && (dwell_q == DWELL_LAST);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      dwell_d = dwell_q;
      wrap_d  = 1'b0;

      if (stop) begin
         state_d = IDLE;
      end else if (start) begin
         state_d = SCAN;
      end

      if (ptr_load) begin
         sel_d   = ptr_in;
         dwell_d = '0;
      end else if (advance) begin
         sel_d   = sel_q + 3'd1;
         dwell_d = '0;
         wrap_d  = (sel_q == 3'd7);
      end else if (state_q == SCAN) begin
         dwell_d = dwell_q + 1'b1;
      end

      valid_d = (state_d == SCAN);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sel_q   <= 3'd0;
         dwell_q <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         dwell_q <= dwell_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign sel   = sel_q;
   assign valid = valid_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_ram8_scan.sv
// Directed bench for ram8_scan; two instances (DWELL=1 and DWELL=3)
// share one clock and one set of inputs.
module tb_ram8_scan;

   logic        clock;
   logic        reset_n;
   logic        load;
   logic [2:0]  waddr;
   logic [15:0] in;
   logic        start;
   logic        stop;
   logic        ptr_load;
   logic [2:0]  ptr_in;

   logic [2:0]  sel1, sel3;
   logic [15:0] out1, out3;
   logic        valid1, valid3;
   logic        wrap1, wrap3;

   int n_tests = 0;
   int n_fail  = 0;

   ram8_scan #(.DWELL(1)) dut1 (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (load),
      .waddr    (waddr),
      .in       (in),
      .start    (start),
      .stop     (stop),
      .ptr_load (ptr_load),
      .ptr_in   (ptr_in),
      .sel      (sel1),
      .out      (out1),
      .valid    (valid1),
      .wrap     (wrap1)
   );

   ram8_scan #(.DWELL(3)) dut3 (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (load),
      .waddr    (waddr),
      .in       (in),
      .start    (start),
      .stop     (stop),
      .ptr_load (ptr_load),
      .ptr_in   (ptr_in),
      .sel      (sel3),
      .out      (out3),
      .valid    (valid3),
      .wrap     (wrap3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n  = 1'b0;
      load     = 1'b0;
      waddr    = 3'd0;
      in       = 16'h0000;
      start    = 1'b0;
      stop     = 1'b0;
      ptr_load = 1'b0;
      ptr_in   = 3'd0;

      #3;
      chk("rst_sel",   32'(sel1),   32'd0);
      chk("rst_out",   32'(out1),   32'd0);
      chk("rst_valid", 32'(valid1), 32'd0);
      chk("rst_wrap",  32'(wrap1),  32'd0);

      step();
      reset_n = 1'b1;

      // Fill entries 0..7 with their own index
      for (int i = 0; i < 8; i++) begin
         load  = 1'b1;
         waddr = 3'(i);
         in    = 16'(i);
         step();
      end
      load = 1'b0;
      chk("idle_valid", 32'(valid1), 32'd0);
      chk("idle_sel",   32'(sel1),   32'd0);

      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_valid1", 32'(valid1), 32'd1);
      chk("start_valid3", 32'(valid3), 32'd1);

      for (int k = 0; k < 10; k++) begin
         chk($sformatf("scan1_sel_k%0d", k),  32'(sel1),  32'(k % 8));
         chk($sformatf("scan1_out_k%0d", k),  32'(out1),  32'(k % 8));
         chk($sformatf("scan1_wrap_k%0d", k), 32'(wrap1), (k == 8) ? 32'd1 : 32'd0);
         chk($sformatf("scan3_sel_k%0d", k),  32'(sel3),  32'(k / 3));
         chk($sformatf("scan3_out_k%0d", k),  32'(out3),  32'(k / 3));
         step();
      end
      step();
      step();
      step();
      chk("pre_ptr_sel1", 32'(sel1), 32'd5);

      // ptr_load with stop while scanning at entry 5
      ptr_load = 1'b1;
      ptr_in   = 3'd2;
      stop     = 1'b1;
      step();
      ptr_load = 1'b0;
      stop     = 1'b0;
      chk("pl_sel1",   32'(sel1),   32'd2);
      chk("pl_valid1", 32'(valid1), 32'd0);
      chk("pl_sel3",   32'(sel3),   32'd2);
      step();
      step();
      chk("pl_hold_sel1",   32'(sel1),   32'd2);
      chk("pl_hold_valid1", 32'(valid1), 32'd0);

      ptr_load = 1'b1;
      ptr_in   = 3'd0;
      step();
      chk("pl0_sel1",  32'(sel1),  32'd0);
      chk("pl0_wrap1", 32'(wrap1), 32'd0);

      ptr_in = 3'd4;
      step();
      ptr_load = 1'b0;
      chk("idle4_sel1", 32'(sel1), 32'd4);
      chk("idle4_out1", 32'(out1), 32'd4);

      load  = 1'b1;
      waddr = 3'd4;
      in    = 16'hBEEF;
      step();
      load = 1'b0;
      chk("beef_out1", 32'(out1), 32'hBEEF);
      ptr_load = 1'b1;
      ptr_in   = 3'd3;
      step();
      ptr_load = 1'b0;
      chk("entry3_out1", 32'(out1), 32'd3);

      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("ss_valid1", 32'(valid1), 32'd0);
      chk("ss_sel1",   32'(sel1),   32'd3);
      step();
      chk("ss_valid1_b", 32'(valid1), 32'd0);

      // Enter SCAN at entry 6, then reset between edges
      start    = 1'b1;
      ptr_load = 1'b1;
      ptr_in   = 3'd6;
      step();
      start    = 1'b0;
      ptr_load = 1'b0;
      chk("scan6_sel1",   32'(sel1),   32'd6);
      chk("scan6_out1",   32'(out1),   32'd6);
      chk("scan6_valid1", 32'(valid1), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_sel1",   32'(sel1),   32'd0);
      chk("async_out1",   32'(out1),   32'd0);
      chk("async_valid1", 32'(valid1), 32'd0);
      chk("async_wrap1",  32'(wrap1),  32'd0);
      step();
      reset_n = 1'b1;
      step();
      step();
      step();
      chk("post_rst_valid1", 32'(valid1), 32'd0);
      chk("post_rst_sel1",   32'(sel1),   32'd0);

      // stop on a cycle with an advance pending
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("adv_sel1", 32'(sel1), 32'd1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stopadv_sel1",   32'(sel1),   32'd2);
      chk("stopadv_valid1", 32'(valid1), 32'd0);
      chk("stopadv_sel3",   32'(sel3),   32'd0);
      step();
      step();
      chk("stopadv_hold1", 32'(sel1), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram8_scan.md
RAM8_SCAN -- requirements
Module: ram8_scan

Interface
REQ-001 Parameter DWELL, default 1, meaning clock cycles the scan pointer holds each entry; legal range 1..15.
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-low reset: clock input 1 rising-edge system clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 load  input  1  write enable for the register bank.
REQ-005 waddr  input  3  write address.
REQ-006 in  input  16  write data.
REQ-007 start  input  1  level; enter SCAN state.
REQ-008 stop  input  1  level; enter IDLE state.
REQ-009 ptr_load  input  1  load scan pointer from ptr_in.
REQ-010 ptr_in  input  3  scan pointer load value.
REQ-011 sel  output  3  current scan pointer; drives the 8-way select.
REQ-012 out  output  16  contents of bank[sel].
REQ-013 valid  output  1  high while in SCAN.
REQ-014 wrap  output  1  one-cycle pulse on pointer advance 7->0.

Function
REQ-015 Bank: 8 x 16-bit registers; on a rising edge with load=1, bank[waddr] SHALL take in; other entries hold.
REQ-016 out SHALL be combinational bank[sel] (no added latency); a write to entry sel SHALL appear on out after the writing edge.
REQ-017 FSM states IDLE, SCAN; IDLE->SCAN when start=1 and stop=0; SCAN->IDLE when stop=1; start and stop both high: stop wins.
REQ-018 valid SHALL be registered state==SCAN, asserting the cycle after the start edge and deasserting the cycle after the stop edge.
REQ-019 Dwell counter: in SCAN, counts 0..DWELL-1; at DWELL-1, sel SHALL advance by 1 modulo 8 and the counter SHALL return to 0.
REQ-020 In IDLE, sel and dwell counter SHALL hold.
REQ-021 Pointer priority: reset > ptr_load > advance; ptr_load SHALL set sel=ptr_in and clear dwell counter in either state.
REQ-022 wrap SHALL be 1 for exactly the cycle after an advance 7->0; ptr_load to 0 SHALL NOT raise wrap.
REQ-023 Writes SHALL proceed in both states and simultaneously with ptr_load or advance.
REQ-024 stop in the same cycle as a pending advance: the advance SHALL still occur on that edge, and no further advance SHALL follow.

Reset
REQ-025 reset_n=0 SHALL immediately and asynchronously clear all bank entries to 16'h0000, sel=0, dwell counter=0, state=IDLE, valid=0, wrap=0.
REQ-026 Reset asserted mid-scan SHALL abort the scan; after release the block SHALL remain IDLE until start.

Structure
REQ-027 State encodings (IDLE=0, SCAN=1) and the DWELL maximum SHALL live in the shared include file.
REQ-028 The read path SHALL instantiate the existing Mux8Way16.
REQ-029 The bank SHALL be a sub-module ram8_bank (clock, reset_n, load, waddr, in, eight 16-bit outputs).

Verification
REQ-030 Reset, write 16'h0000..16'h0007 to entries 0..7, DWELL=1, start -> sel 0,1,...,7,0 on successive cycles, out equals sel, and wrap is high only on the cycle sel returns to 0.
REQ-031 DWELL=3, start -> each sel value is held exactly 3 cycles; valid rises one cycle after start.
REQ-032 SCAN at sel=5, ptr_load=1, ptr_in=2 with stop=1 -> sel=2 next cycle, IDLE, valid=0, and sel stays 2.
REQ-033 In IDLE at sel=4, write 16'hBEEF to entry 4 -> out=16'hBEEF after the edge; entry 3 is unchanged.
REQ-034 start=stop=1 from IDLE -> remains IDLE and valid stays 0; reset_n low mid-scan at sel=6 -> sel=0, out=0, and valid=0 without waiting for a clock edge.
